// File: rtl/register_file_mp.sv
// Multi-port register file for decode: NUM_RD read ports with bypass and hold,
// two write ports (B has priority over A), and a pending-write scoreboard.
module register_file_mp #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 8,
  parameter  int NUM_RD = 2,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic [NUM_RD-1:0]          i_rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
  output logic [NUM_RD-1:0]          o_rd_ready,
  output logic                       o_hazard,
  input  logic                       i_wa_en,
  input  logic [ADDR_W-1:0]          i_wa_addr,
  input  logic [DATA_W-1:0]          i_wa_data,
  input  logic                       i_wb_en,
  input  logic [ADDR_W-1:0]          i_wb_addr,
  input  logic [DATA_W-1:0]          i_wb_data,
  input  logic                       i_rsv_en,
  input  logic [ADDR_W-1:0]          i_rsv_addr,
  output logic [DEPTH-1:0]           o_pending
);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending_next;

  // Storage: per-register write select, port B overriding port A on collision.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        if (i_wb_en && (i_wb_addr == ADDR_W'(r))) begin
          regs[r] <= i_wb_data;
        end else if (i_wa_en && (i_wa_addr == ADDR_W'(r))) begin
          regs[r] <= i_wa_data;
        end
      end
    end
  end

  // Scoreboard: a new reservation supersedes a same-cycle writeback.
  always_comb begin
    pending_next = o_pending;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      if (i_rsv_en && (i_rsv_addr == ADDR_W'(r))) begin
        pending_next[r] = 1'b1;
      end else if ((i_wa_en && (i_wa_addr == ADDR_W'(r))) ||
                   (i_wb_en && (i_wb_addr == ADDR_W'(r)))) begin
        pending_next[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_pending <= '0;
    end else begin
      o_pending <= pending_next;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    logic [ADDR_W-1:0] addr;
    logic              wa_hit;
    logic              wb_hit;
    logic [DATA_W-1:0] fwd;
    logic [DATA_W-1:0] hold_q;

    assign addr   = i_rd_addr[k*ADDR_W +: ADDR_W];
    assign wa_hit = i_wa_en & (i_wa_addr == addr);
    assign wb_hit = i_wb_en & (i_wb_addr == addr);

    always_comb begin
      fwd = regs[addr];
      if (wb_hit) begin
        fwd = i_wb_data;
      end else if (wa_hit) begin
        fwd = i_wa_data;
      end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        hold_q <= '0;
      end else if (i_rd_en[k]) begin
        hold_q <= fwd;
      end
    end

    assign o_rd_data[k*DATA_W +: DATA_W] = i_rd_en[k] ? fwd : hold_q;
    assign o_rd_ready[k] = ~o_pending[addr] | wa_hit | wb_hit;
  end

  assign o_hazard = |(i_rd_en & ~o_rd_ready);

endmodule
